// File: rtl/cordic_issue_ctrl_pkg.sv
// Shared types for the CORDIC issue controller.
// Result entries pair the pipeline output with the requester tag.
package cordic_ctrl_pkg;

  localparam int LATENCY_DEF = 5;
  localparam int TAG_W_DEF   = 1;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  typedef struct packed {
    logic [31:0] data;
    tag_t        tag;
  } res_entry_t;

endpackage

// File: rtl/cordic_issue_ctrl_if.sv
// Requester and result handshakes of the CORDIC issue controller.
// The controller sits on the slave side.
interface cordic_issue_ctrl_if #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 1
);

  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                res_valid;
  logic [31:0]         res_data;
  logic [TAG_W-1:0]    res_tag;
  logic                res_ready;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_tag
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_tag
  );

endinterface

// File: rtl/cordic_issue_ctrl_fifo.sv
// Synchronous result FIFO; head is gated to zero when empty.
// Count is registered, so there is no fall-through.
module ctrl_result_fifo
  import cordic_ctrl_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = res_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_en;
  logic          rd_en;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst) !(push && full)
  );

endmodule

// File: rtl/cordic_issue_ctrl.sv
// Round-robin issue into a fixed-latency CORDIC pipeline,
// credit-gated so every result fits in the result FIFO.
module cordic_issue_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int LATENCY    = LATENCY_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  cordic_issue_ctrl_if.slave  bus,
  output logic [31:0]         dp_in,
  input  logic [31:0]         dp_out,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [PW-1:0]                ptr;
  logic [IW-1:0]                inflight;
  logic [LATENCY-1:0]           sr_vld;
  logic [LATENCY-1:0][TAG_W-1:0] sr_tag;
  logic [CW-1:0]                fifo_cnt;
  logic                         fifo_full;
  logic                         fifo_empty;
  entry_t                       fifo_din;
  entry_t                       fifo_dout;
  logic                         credit;
  logic                         found;
  logic                         issue;
  logic                         cap;
  logic                         pop;
  logic [PW-1:0]                g;
  logic [31:0]                  sel_data;

  // Both terms are registered: a pop frees its credit one cycle later.
  assign credit = (32'(fifo_cnt) + 32'(inflight)) < 32'(FIFO_DEPTH);

  // Two passes: from ptr upward, then wrap from zero.
  always_comb begin
    found = 1'b0;
    g     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && bus.req_valid[j] && PW'(j) >= ptr) begin
        found = 1'b1;
        g     = PW'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        g     = PW'(j);
      end
    end
  end

  assign issue = rst && credit && found;

  always_comb begin
    sel_data      = '0;
    bus.req_ready = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (PW'(j) == g) begin
        sel_data         = bus.req_data[j*32 +: 32];
        bus.req_ready[j] = issue;
      end
    end
  end

  assign dp_in = issue ? sel_data : '0;
  assign cap   = sr_vld[LATENCY-1];
  assign pop   = bus.res_valid && bus.res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      inflight <= '0;
      sr_vld   <= '0;
      sr_tag   <= '0;
    end else begin
      sr_vld[0] <= issue;
      sr_tag[0] <= issue ? TAG_W'(g) : '0;
      for (int k = 1; k < LATENCY; k++) begin
        sr_vld[k] <= sr_vld[k-1];
        sr_tag[k] <= sr_tag[k-1];
      end
      if (issue) begin
        ptr <= (g == PW'(N_REQ - 1)) ? '0 : g + PW'(1);
      end
      unique case ({issue, cap})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign fifo_din = '{data: dp_out, tag: sr_tag[LATENCY-1]};

  ctrl_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bus.res_valid = !fifo_empty;
  assign bus.res_data  = fifo_dout.data;
  assign bus.res_tag   = fifo_dout.tag;
  assign busy          = (inflight != '0) || !fifo_empty;

endmodule

// File: tb/tb_cordic_issue_ctrl.sv
// Bench for cordic_issue_ctrl: a cosine pipeline stand-in, a
// queue-based occupancy model checked every cycle, directed cases.
module tb_cordic_issue_ctrl;

  localparam int N_REQ = 2;
  localparam int TAG_W = 1;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dp_in;
  logic [31:0] dp_out;
  logic        busy;

  always #5 clk = ~clk;

  cordic_issue_ctrl_if #(.N_REQ(N_REQ), .TAG_W(TAG_W)) bus ();

  cordic_issue_ctrl #(
    .N_REQ(N_REQ), .TAG_W(TAG_W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .dp_in  (dp_in),
    .dp_out (dp_out),
    .busy   (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h",
                  name, $time, act, exp);
  endtask

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic   s;
    int     e;
    longint man;
    real    a;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    man = longint'((a - 1.0) * 8388608.0);
    if (man == 64'd8388608) begin man = 0; e++; end
    return {s, 8'(e + 127), 23'(man)};
  endfunction

  function automatic logic [31:0] cosf(input logic [31:0] x);
    return r2f($cos(f2r(x)));
  endfunction

  // Stand-in for the external fixed-latency cosine pipeline.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= cosf(dp_in);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign dp_out = pipe[LAT-1];

  typedef struct {
    logic [31:0] d;
    int          tag;
    int          due;
  } op_t;

  op_t infl [$];
  op_t fq   [$];
  int  mptr = 0;
  int  cyc  = 0;

  // Model: occupancy is everything issued and not yet popped.
  always @(negedge clk) begin : compare
    int          gi;
    logic [1:0]  e_rdy;
    logic [31:0] e_dp;
    if (!rst) begin
      infl.delete();
      fq.delete();
      mptr = 0;
      check("rst_ready", bus.req_ready, 0);
      check("rst_dp_in", dp_in, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_busy", busy, 0);
    end else begin
      gi = -1;
      for (int k = 0; k < N_REQ; k++) begin
        if (gi < 0 && bus.req_valid[(mptr + k) % N_REQ]) gi = (mptr + k) % N_REQ;
      end
      if (fq.size() + infl.size() >= DEPTH) gi = -1;
      e_rdy = (gi >= 0) ? 2'(1 << gi) : 2'b00;
      e_dp  = (gi >= 0) ? bus.req_data[gi*32 +: 32] : 32'h0;
      check("m_ready", bus.req_ready, e_rdy);
      check("m_dp_in", dp_in, e_dp);
      check("m_res_valid", bus.res_valid, fq.size() > 0);
      check("m_res_data", bus.res_data, fq.size() > 0 ? fq[0].d : 32'h0);
      check("m_res_tag", bus.res_tag, fq.size() > 0 ? fq[0].tag : 0);
      check("m_busy", busy, (fq.size() + infl.size()) > 0);
      if (fq.size() > 0 && bus.res_ready) void'(fq.pop_front());
      if (infl.size() > 0 && infl[0].due == cyc) fq.push_back(infl.pop_front());
      if (gi >= 0) begin
        infl.push_back('{cosf(e_dp), gi, cyc + LAT});
        mptr = (gi + 1) % N_REQ;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0]  grants [6];
    int          tags [$];
    logic [31:0] ops [$];
    logic [31:0] pops [$];
    int          n_iss;
    int          lat;
    int          stale;
    real         diff;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;

    // Reset holds everything quiet even with requests pending.
    tick();
    bus.req_valid = 2'b11;
    #1;
    check("reset_ready", bus.req_ready, 2'b00);
    check("reset_dp_in", dp_in, 0);
    check("reset_busy", busy, 0);
    tick();
    bus.req_valid = 2'b00;
    rst = 1'b1;

    // Fairness: alternating grants, tags returned in the same order.
    bus.res_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i < 6) begin
        bus.req_valid = 2'b11;
        bus.req_data  = {32'h3F400000 + (i << 18), 32'h3F000000 + (i << 18)};
      end else begin
        bus.req_valid = 2'b00;
      end
      #1;
      if (i < 6) grants[i] = bus.req_ready;
      if (bus.res_valid && bus.res_ready) tags.push_back(int'(bus.res_tag));
      tick();
    end
    for (int i = 0; i < 6; i++)
      check($sformatf("fair_grant%0d", i), grants[i], (i % 2) ? 2'b10 : 2'b01);
    check("fair_ntags", tags.size(), 6);
    for (int i = 0; i < tags.size() && i < 6; i++)
      check($sformatf("fair_tag%0d", i), tags[i], i % 2);

    // Single operation: latency and cosine value.
    bus.res_ready = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_data  = {32'h0, 32'h3F000000};
    #1;
    check("single_grant", bus.req_ready, 2'b01);
    check("single_dp_in", dp_in, 32'h3F000000);
    tick();
    bus.req_valid = 2'b00;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (bus.res_valid) begin
        lat = k;
        break;
      end
      tick();
    end
    check("single_latency", lat, 6);
    check("single_tag", bus.res_tag, 0);
    diff = f2r(bus.res_data) - 0.87758;
    if (diff < 0.0) diff = -diff;
    check("single_cos", diff < (1.0 / 131072.0), 1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Idle: nothing issued, pointer held at 1 after the req0 grant.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_dp_in", dp_in, 0);
      check("idle_busy", busy, 0);
    end
    bus.req_valid = 2'b11;
    #1;
    check("idle_ptr", bus.req_ready, 2'b10);
    bus.req_valid = 2'b00;
    tick();

    // Backpressure: fill the FIFO, then drain in order.
    n_iss = 0;
    for (int i = 0; i < 20; i++) begin
      bus.req_valid = 2'b01;
      bus.req_data  = {32'h0, 32'h3E000000 + (i << 19)};
      #1;
      if (bus.req_ready[0]) begin
        n_iss++;
        ops.push_back(bus.req_data[31:0]);
      end
      tick();
    end
    check("bp_issues", n_iss, 8);
    #1;
    check("bp_blocked", bus.req_ready, 2'b00);
    check("bp_busy", busy, 1);
    bus.res_ready = 1'b1;
    #1;
    check("bp_no_bypass", bus.req_ready, 2'b00);
    pops.push_back(bus.res_data);
    tick();
    #1;
    check("bp_resume", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    for (int i = 0; i < 20 && pops.size() < 8; i++) begin
      #1;
      if (bus.res_valid) pops.push_back(bus.res_data);
      tick();
    end
    check("bp_npops", pops.size(), 8);
    for (int i = 0; i < pops.size() && i < ops.size(); i++)
      check($sformatf("bp_order%0d", i), pops[i], cosf(ops[i]));
    for (int i = 0; i < 20 && busy; i++) tick();
    check("bp_drained", busy, 0);

    // Capture and pop in the same cycle with FIFO at 7, one in flight.
    bus.res_ready = 1'b0;
    n_iss = 0;
    for (int i = 0; i < 12; i++) begin
      bus.req_valid = 2'b01;
      bus.req_data  = {32'h0, 32'h3F200000 + (i << 17)};
      #1;
      if (bus.req_ready[0]) n_iss++;
      tick();
    end
    check("sim_issues", n_iss, 8);
    bus.res_ready = 1'b1;
    #1;
    check("sim_no_grant", bus.req_ready, 2'b00);
    tick();
    check("sim_count", dut.fifo_cnt, 7);
    check("sim_grant_next", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    for (int i = 0; i < 40 && busy; i++) tick();
    check("sim_drained", busy, 0);

    // Reset with three in flight and two buffered.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = (i < 5) ? 2'b01 : 2'b00;
      bus.req_data  = {32'h0, 32'h3E800000 + (i << 19)};
      if (i < 7) tick();
    end
    check("mid_busy", busy, 1);
    check("mid_buffered", bus.res_valid, 1);
    rst = 1'b0;
    bus.req_valid = 2'b01;
    #1;
    check("mid_rst_ready", bus.req_ready, 2'b00);
    check("mid_rst_dp_in", dp_in, 0);
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_data", bus.res_data, 0);
    check("mid_rst_tag", bus.res_tag, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.res_valid) stale++;
      tick();
    end
    check("mid_no_stale", stale, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_issue_ctrl.md
Name: cordic_issue_ctrl

Overview:
- Sequences and shares the unrolled, fixed-latency CORDIC cosine pipeline between N_REQ requesters.
- Arbitrates requests round-robin and drives the pipeline input one operand per cycle.
- Tracks in-flight operands with a valid/tag shift register.
- Buffers results in a FIFO with a ready/valid output. The pipeline has no stall input, so issue is credit-gated so that no result is ever dropped.

Parameters:
- N_REQ, 2, number of requesters.
- TAG_W, 1, requester-ID width; must be at least clog2(N_REQ).
- LATENCY, 5, number of pipeline register stages from dp_in to dp_out.
- FIFO_DEPTH, 8, result-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  32*N_REQ  IEEE-754 operands; requester i occupies bits [32i+31:32i].
- req_ready  out  N_REQ  one-hot grant; at most one bit high.
- dp_in  out  32  to the pipeline input.
- dp_out  in  32  from the pipeline output.
- res_valid  out  1  result available.
- res_data  out  32  IEEE-754 result at the FIFO head.
- res_tag  out  TAG_W  requester ID of the head entry.
- res_ready  in  1  consumer accepts the head entry.
- busy  out  1  high when any operand is in flight or the FIFO is non-empty.

Behaviour:
- Reset (rst low, asynchronous) clears:
  - valid/tag shift register
  - FIFO pointers and count
  - round-robin pointer (to 0)
  - in-flight counter
- Outputs while in reset: req_ready=0, dp_in=0, res_valid=0, res_data=0, res_tag=0, busy=0.
- Reset mid-operation discards all in-flight and buffered results. The pipeline's own registers are not flushed, but their outputs are ignored because the valid bits are cleared.
- Credit:
  - occ = fifo_count + inflight, both registered.
  - Issue is allowed only if occ < FIFO_DEPTH.
  - A pop in the current cycle does not free a credit until the next cycle; there is no same-cycle bypass.
- Arbitration:
  - Combinational, from req_valid and the registered pointer ptr.
  - Search order is ptr, ptr+1, …, wrapping mod N_REQ; the first valid requester wins.
  - req_ready[g]=1 only when credit is available. Requesters must not make req_valid depend on req_ready.
  - On a handshake, ptr <= g+1 mod N_REQ. With no grant, ptr holds.
- Issue (cycle t):
  - dp_in = req_data[g]; otherwise dp_in = 32'h0.
  - Shift-register entry 0 <= {1, g}; otherwise {0, 0}. The register shifts every cycle, LATENCY entries.
- Capture:
  - When the last shift-register entry is valid, the result is on dp_out during cycle t+LATENCY.
  - At the end of that cycle, dp_out and the tag are written to the FIFO.
  - The credit rule guarantees the FIFO is never full at capture. Overflow is a checked assertion.
- Output:
  - res_valid = FIFO not empty (registered count). There is no fall-through.
  - First res_valid occurs in cycle t+LATENCY+1.
  - Pop when res_valid && res_ready.
  - Simultaneous capture and pop: count is unchanged and both pointers advance.
- inflight:
  - +1 on issue, −1 on capture; both in the same cycle leaves it unchanged.
  - Range 0..LATENCY.
- Throughput: one issue per cycle while res_ready is held high.
- Ordering: results leave in issue order.

Decomposition:
- Package cordic_ctrl_pkg holds:
  - LATENCY default
  - tag typedef
  - FIFO entry struct {data[31:0], tag}
- Sub-module ctrl_result_fifo: synchronous FIFO, same clk/rst, with push/pop/full/empty/count.
- The arbiter, shift register and credit logic live in the top controller.

Test Plan:
- Single op: req0 with 32'h3F000000 (0.5) issued at cycle t; dp_in=32'h3F000000 in cycle t; res_valid rises at cycle t+6. Required result: res_data ≈ cos 0.5 = 0.87758, within 2^-17, with res_tag=0.
- Fairness: both requesters hold valid for 6 cycles with res_ready=1. Required grants: 0,1,0,1,0,1; results are returned in the same tag order.
- Backpressure: res_ready=0 with req0 always valid. Required: exactly 8 issues, then req_ready=0. After the FIFO fills, busy=1 and no entry is lost. Raising res_ready then drains 8 results in order, and issue resumes one cycle after the first pop.
- Simultaneous events: with the FIFO at 7 and 1 in flight, assert pop and capture in the same cycle. Required: count stays 7, no grant that cycle, and a grant on the next cycle.
- Reset mid-flight: deassert rst with 3 in flight and 2 buffered. Required: all outputs are 0 immediately; after release, no stale res_valid appears within 10 cycles.
- Idle: no requests. Required: dp_in=0, busy=0, and ptr unchanged.
